// File: rtl/arc4_pkg.sv
// ARC4 shared types: PRGA state encoding,
// byte type and default printable range.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LEN,
    S_WT_LEN,
    S_WR_PT0,
    S_RD_SI,
    S_WT_SI,
    S_RD_SJ,
    S_WT_SJ,
    S_WR_SJ,
    S_WR_SI,
    S_RD_PAD,
    S_WT_PAD,
    S_WR_PT,
    S_DONE
  } prga_state_t;

  localparam byte_t ASCII_LO_DEF = 8'h20;
  localparam byte_t ASCII_HI_DEF = 8'h7E;

endpackage

// File: rtl/arc4_byte_grade.sv
// Printable-range check for one plaintext byte.
// With CHECK_EN=0 every byte counts as legal.
import arc4_pkg::*;

module arc4_byte_grade #(
  parameter bit         CHECK_EN = 1'b1,
  parameter logic [7:0] ASCII_LO = ASCII_LO_DEF,
  parameter logic [7:0] ASCII_HI = ASCII_HI_DEF
) (
  input  logic [7:0] b,
  output logic       legal
);

  logic in_rng;

  // range compare, bypassed when grading is off
  always_comb begin
    in_rng = (b >= ASCII_LO) && (b <= ASCII_HI);
    legal  = !CHECK_EN || in_rng;
  end

endmodule

// File: rtl/prga_check.sv
// ARC4 PRGA decrypt engine with plaintext grading.
// All outputs are registered; loads happen on state entry.
import arc4_pkg::*;

module prga_check #(
  parameter int         MEM_LAT     = 1,
  parameter bit         CHECK_EN    = 1'b1,
  parameter logic [7:0] ASCII_LO    = ASCII_LO_DEF,
  parameter logic [7:0] ASCII_HI    = ASCII_HI_DEF,
  parameter bit         EARLY_ABORT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       done,
  output logic       result_ok,
  output logic [7:0] fail_idx,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  localparam logic [1:0] WT_LAST = 2'(MEM_LAT - 1);

  prga_state_t state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  byte_t       i_q, i_d, j_q, j_d;
  logic [8:0]  k_q, k_d;
  byte_t       len_q, len_d, si_q, si_d, sj_q, sj_d;
  logic        rdy_q, rdy_d, done_q, done_d;
  logic        ok_q, ok_d;
  byte_t       fidx_q, fidx_d;
  byte_t       sa_q, sa_d, swd_q, swd_d;
  logic        swe_q, swe_d;
  byte_t       ca_q, ca_d, pa_q, pa_d, pwd_q, pwd_d;
  logic        pwe_q, pwe_d;

  logic wt_last, in_wt, byte_ok, last_k, abort;

  arc4_byte_grade #(
    .CHECK_EN (CHECK_EN),
    .ASCII_LO (ASCII_LO),
    .ASCII_HI (ASCII_HI)
  ) u_grade (
    .b     (pwd_q),
    .legal (byte_ok)
  );

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= 9'd1;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      fidx_q  <= '0;
      sa_q    <= '0;
      swd_q   <= '0;
      swe_q   <= 1'b0;
      ca_q    <= '0;
      pa_q    <= '0;
      pwd_q   <= '0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      fidx_q  <= fidx_d;
      sa_q    <= sa_d;
      swd_q   <= swd_d;
      swe_q   <= swe_d;
      ca_q    <= ca_d;
      pa_q    <= pa_d;
      pwd_q   <= pwd_d;
      pwe_q   <= pwe_d;
    end
  end

  // next state; WT_* states hold for MEM_LAT cycles
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    wt_last = (wcnt_q == WT_LAST);
    in_wt   = (state_q == S_WT_LEN) || (state_q == S_WT_SI)
           || (state_q == S_WT_SJ) || (state_q == S_WT_PAD);
    last_k  = ((k_q + 9'd1) == {1'b0, len_q});
    abort   = EARLY_ABORT && !byte_ok;
    if (in_wt && !wt_last) begin
      wcnt_d = wcnt_q + 2'd1;
    end else begin
      unique case (state_q)
        S_IDLE:   if (en && rdy_q) state_d = S_RD_LEN;
        S_RD_LEN: state_d = S_WT_LEN;
        S_WT_LEN: state_d = S_WR_PT0;
        S_WR_PT0: state_d = (len_q <= 8'd1) ? S_DONE : S_RD_SI;
        S_RD_SI:  state_d = S_WT_SI;
        S_WT_SI:  state_d = S_RD_SJ;
        S_RD_SJ:  state_d = S_WT_SJ;
        S_WT_SJ:  state_d = S_WR_SJ;
        S_WR_SJ:  state_d = S_WR_SI;
        S_WR_SI:  state_d = S_RD_PAD;
        S_RD_PAD: state_d = S_WT_PAD;
        S_WT_PAD: state_d = S_WR_PT;
        S_WR_PT:  state_d = (last_k || abort) ? S_DONE : S_RD_SI;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // registered outputs loaded on entry to each state
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    len_d  = len_q;
    si_d   = si_q;
    sj_d   = sj_q;
    rdy_d  = rdy_q;
    done_d = 1'b0;
    ok_d   = ok_q;
    fidx_d = fidx_q;
    sa_d   = sa_q;
    swd_d  = swd_q;
    swe_d  = 1'b0;
    ca_d   = ca_q;
    pa_d   = pa_q;
    pwd_d  = pwd_q;
    pwe_d  = 1'b0;
    if (state_q == S_WR_PT) begin
      k_d = k_q + 9'd1;
      if (!byte_ok) begin
        ok_d = 1'b0;
        if (ok_q) fidx_d = k_q[7:0];
      end
    end
    if (state_d != state_q) begin
      unique case (state_d)
        S_RD_LEN: begin
          rdy_d  = 1'b0;
          i_d    = '0;
          j_d    = '0;
          k_d    = 9'd1;
          ok_d   = 1'b1;
          fidx_d = '0;
          ca_d   = '0;
        end
        S_WR_PT0: begin
          len_d = ct_rddata;
          pa_d  = '0;
          pwd_d = ct_rddata;
          pwe_d = 1'b1;
        end
        S_RD_SI: begin
          i_d  = i_q + 8'd1;
          sa_d = i_q + 8'd1;
        end
        S_RD_SJ: begin
          si_d = s_rddata;
          j_d  = j_q + s_rddata;
          sa_d = j_q + s_rddata;
        end
        S_WR_SJ: begin
          sj_d  = s_rddata;
          sa_d  = j_q;
          swd_d = si_q;
          swe_d = 1'b1;
        end
        S_WR_SI: begin
          sa_d  = i_q;
          swd_d = sj_q;
          swe_d = 1'b1;
        end
        S_RD_PAD: begin
          sa_d = si_q + sj_q;
          ca_d = k_q[7:0];
        end
        S_WR_PT: begin
          pa_d  = k_q[7:0];
          pwd_d = s_rddata ^ ct_rddata;
          pwe_d = 1'b1;
        end
        S_DONE:  done_d = 1'b1;
        S_IDLE:  rdy_d  = 1'b1;
        default: ;
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign done      = done_q;
  assign result_ok = ok_q;
  assign fail_idx  = fidx_q;
  assign s_addr    = sa_q;
  assign s_wrdata  = swd_q;
  assign s_wren    = swe_q;
  assign ct_addr   = ca_q;
  assign pt_addr   = pa_q;
  assign pt_wrdata = pwd_q;
  assign pt_wren   = pwe_q;

endmodule

// File: tb/tb_prga_check.sv
// Directed bench for prga_check: three instances
// (lat 1 abort, lat 3 abort, lat 1 no-abort).
module tb_prga_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       en [3];
  logic       rdy [3];
  logic       done [3];
  logic       result_ok [3];
  logic [7:0] fail_idx [3];
  logic [7:0] s_addr [3];
  logic [7:0] s_rddata [3];
  logic [7:0] s_wrdata [3];
  logic       s_wren [3];
  logic [7:0] ct_addr [3];
  logic [7:0] ct_rddata [3];
  logic [7:0] pt_addr [3];
  logic [7:0] pt_wrdata [3];
  logic       pt_wren [3];

  logic [7:0] smem [3][256];
  logic [7:0] ctmem [3][256];
  logic [7:0] ptmem [3][256];
  logic [7:0] sp [3][3];
  logic [7:0] cp [3][3];
  int         pt_n [3];
  int         s_n [3];

  logic       ld_we;
  logic       clr;
  int         ld_g;
  int         ld_m;
  logic [7:0] ld_a;
  logic [7:0] ld_d;

  logic [7:0] ks [256];
  logic [7:0] es [256];

  int n_chk = 0;
  int n_pass = 0;

  localparam logic [7:0] KCT [10] = '{8'h0A, 8'hBB, 8'hF3, 8'h16,
    8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  localparam logic [7:0] KPT [10] = '{8'h0A, 8'h50, 8'h6C, 8'h61,
    8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  localparam logic [7:0] WCT [6] = '{8'h06, 8'h43, 8'h47, 8'h17,
    8'h4E, 8'h08};
  localparam logic [7:0] WPT [6] = '{8'h06, 8'h41, 8'h42, 8'h10,
    8'h43, 8'h05};

  prga_check #(.MEM_LAT(1), .EARLY_ABORT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]),
    .done(done[0]), .result_ok(result_ok[0]),
    .fail_idx(fail_idx[0]), .s_addr(s_addr[0]),
    .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]),
    .s_wren(s_wren[0]), .ct_addr(ct_addr[0]),
    .ct_rddata(ct_rddata[0]), .pt_addr(pt_addr[0]),
    .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
  );

  prga_check #(.MEM_LAT(3), .EARLY_ABORT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]),
    .done(done[1]), .result_ok(result_ok[1]),
    .fail_idx(fail_idx[1]), .s_addr(s_addr[1]),
    .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]),
    .s_wren(s_wren[1]), .ct_addr(ct_addr[1]),
    .ct_rddata(ct_rddata[1]), .pt_addr(pt_addr[1]),
    .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
  );

  prga_check #(.MEM_LAT(1), .EARLY_ABORT(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]),
    .done(done[2]), .result_ok(result_ok[2]),
    .fail_idx(fail_idx[2]), .s_addr(s_addr[2]),
    .s_rddata(s_rddata[2]), .s_wrdata(s_wrdata[2]),
    .s_wren(s_wren[2]), .ct_addr(ct_addr[2]),
    .ct_rddata(ct_rddata[2]), .pt_addr(pt_addr[2]),
    .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2])
  );

  // memories with a 3-deep read pipe, write counters, bench load port
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      sp[g][0] <= smem[g][s_addr[g]];
      sp[g][1] <= sp[g][0];
      sp[g][2] <= sp[g][1];
      cp[g][0] <= ctmem[g][ct_addr[g]];
      cp[g][1] <= cp[g][0];
      cp[g][2] <= cp[g][1];
      if (s_wren[g]) begin
        smem[g][s_addr[g]] <= s_wrdata[g];
        s_n[g] <= s_n[g] + 1;
      end
      if (pt_wren[g]) begin
        ptmem[g][pt_addr[g]] <= pt_wrdata[g];
        pt_n[g] <= pt_n[g] + 1;
      end
      if (clr) begin
        s_n[g]  <= 0;
        pt_n[g] <= 0;
      end
    end
    if (ld_we) begin
      case (ld_m)
        0:       smem[ld_g][ld_a]  <= ld_d;
        1:       ctmem[ld_g][ld_a] <= ld_d;
        default: ptmem[ld_g][ld_a] <= ld_d;
      endcase
    end
  end

  // read data taps the pipe stage matching each instance latency
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      s_rddata[g]  = sp[g][(g == 1) ? 2 : 0];
      ct_rddata[g] = cp[g][(g == 1) ? 2 : 0];
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic ld(input int g, input int m, input int a,
                    input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1;
    ld_g  = g;
    ld_m  = m;
    ld_a  = a[7:0];
    ld_d  = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic clear_cnt();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic load_s(input int g, input bit ident);
    for (int a = 0; a < 256; a++)
      ld(g, 0, a, ident ? a[7:0] : ks[a]);
  endtask

  task automatic load_key_ct(input int g);
    for (int a = 0; a < 10; a++) ld(g, 1, a, KCT[a]);
    for (int a = 0; a < 16; a++) ld(g, 2, a, 8'hEE);
    clear_cnt();
  endtask

  task automatic load_wrong_ct(input int g);
    for (int a = 0; a < 6; a++) ld(g, 1, a, WCT[a]);
    for (int a = 0; a < 16; a++) ld(g, 2, a, 8'hEE);
    clear_cnt();
  endtask

  task automatic run(input int g, output int edges, output int dones);
    @(negedge clk);
    en[g] = 1'b1;
    @(posedge clk);
    #1;
    en[g] = 1'b0;
    edges = 0;
    dones = 0;
    while (!rdy[g] && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
      if (done[g]) dones++;
    end
  endtask

  task automatic check_key(input int g, input int exp_edges);
    int edges, dones, bad;
    run(g, edges, dones);
    chk($sformatf("key%0d_edges", g), edges, exp_edges);
    chk($sformatf("key%0d_done", g), dones, 1);
    chk($sformatf("key%0d_ok", g), result_ok[g], 1);
    chk($sformatf("key%0d_fidx", g), fail_idx[g], 0);
    for (int a = 0; a < 10; a++)
      chk($sformatf("key%0d_pt%0d", g, a), ptmem[g][a], KPT[a]);
    bad = 0;
    for (int a = 0; a < 256; a++)
      if (smem[g][a] !== es[a]) bad++;
    chk($sformatf("key%0d_s_bad", g), bad, 0);
    chk($sformatf("key%0d_s_wr", g), s_n[g], 18);
  endtask

  initial begin
    logic [7:0] key [3];
    logic [7:0] t, jj, ii;
    int edges, dones, bad;
    key = '{8'h4B, 8'h65, 8'h79};
    for (int a = 0; a < 256; a++) ks[a] = a[7:0];
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      jj = jj + ks[a] + key[a % 3];
      t = ks[a]; ks[a] = ks[jj]; ks[jj] = t;
    end
    es = ks;
    ii = 0;
    jj = 0;
    for (int n = 1; n < 10; n++) begin
      ii = ii + 1;
      jj = jj + es[ii];
      t = es[ii]; es[ii] = es[jj]; es[jj] = t;
    end

    for (int g = 0; g < 3; g++) en[g] = 1'b0;
    ld_we = 1'b0;
    clr   = 1'b0;
    ld_g  = 0;
    ld_m  = 0;
    ld_a  = '0;
    ld_d  = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_rdy", rdy[0], 1);
    chk("rst_done", done[0], 0);
    chk("rst_ok", result_ok[0], 0);
    chk("rst_fidx", fail_idx[0], 0);
    chk("rst_swren", s_wren[0], 0);
    chk("rst_ptwren", pt_wren[0], 0);
    chk("rst_saddr", s_addr[0], 0);
    chk("rst_ctaddr", ct_addr[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    load_s(0, 1'b0);
    load_s(1, 1'b0);
    load_key_ct(0);
    load_key_ct(1);
    check_key(0, 85);
    check_key(1, 141);

    load_s(0, 1'b1);
    load_s(2, 1'b1);
    load_wrong_ct(0);
    load_wrong_ct(2);
    run(0, edges, dones);
    chk("ab_edges", edges, 31);
    chk("ab_done", dones, 1);
    chk("ab_ok", result_ok[0], 0);
    chk("ab_fidx", fail_idx[0], 3);
    chk("ab_pt_n", pt_n[0], 4);
    for (int a = 0; a < 4; a++)
      chk($sformatf("ab_pt%0d", a), ptmem[0][a], WPT[a]);
    chk("ab_pt4", ptmem[0][4], 8'hEE);
    chk("ab_pt5", ptmem[0][5], 8'hEE);
    run(2, edges, dones);
    chk("na_edges", edges, 49);
    chk("na_ok", result_ok[2], 0);
    chk("na_fidx", fail_idx[2], 3);
    chk("na_pt_n", pt_n[2], 6);
    for (int a = 0; a < 6; a++)
      chk($sformatf("na_pt%0d", a), ptmem[2][a], WPT[a]);

    for (int L = 0; L < 2; L++) begin
      ld(0, 1, 0, L[7:0]);
      ld(0, 2, 0, 8'hEE);
      ld(0, 2, 1, 8'hEE);
      clear_cnt();
      run(0, edges, dones);
      chk($sformatf("len%0d_edges", L), edges, 4);
      chk($sformatf("len%0d_done", L), dones, 1);
      chk($sformatf("len%0d_ok", L), result_ok[0], 1);
      chk($sformatf("len%0d_fidx", L), fail_idx[0], 0);
      chk($sformatf("len%0d_pt_n", L), pt_n[0], 1);
      chk($sformatf("len%0d_s_n", L), s_n[0], 0);
      chk($sformatf("len%0d_pt0", L), ptmem[0][0], L);
      chk($sformatf("len%0d_pt1", L), ptmem[0][1], 8'hEE);
    end

    load_s(0, 1'b0);
    load_key_ct(0);
    @(negedge clk);
    en[0] = 1'b1;
    @(posedge clk);
    #1;
    en[0] = 1'b0;
    for (int c = 0; c < 100 && !s_wren[0]; c++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_wrsj_seen", s_wren[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_swren", s_wren[0], 0);
    chk("mid_rdy", rdy[0], 1);
    chk("mid_ptwren", pt_wren[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int a = 0; a < 256; a++)
      if (smem[0][a] !== ks[a]) bad++;
    chk("mid_s_untouched", bad, 0);
    load_key_ct(0);
    check_key(0, 85);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
